// File: rtl/motor_speed_ramp.sv
// motor_speed_ramp
// Setpoint stage feeding the DC motor PWM controller. It accepts a signed
// percent-speed command, slews the applied speed toward it by 1 % per step
// interval, and holds zero speed for a dead time before any reversal.
//
// State table:
//   state    | meaning
//   IDLE     | applied speed equals last accepted command; ready for a new one
//   RAMP     | stepping mag toward target (down to zero first when reversing)
//   DEADTIME | mag is zero, waiting out the dead time before flipping dir
//
// Ports:
//   i_Clk           system clock
//   i_Rst_L         synchronous active-low reset
//   i_Cmd_Valid     command strobe
//   i_Cmd_Speed     signed percent command, -100..+100 (clamped beyond)
//   o_Cmd_Ready     command accepted this cycle when high together with valid
//   o_Control_Range applied magnitude * MULTIPLY_BY, registered
//   o_Direction     0 = clockwise, 1 = counterclockwise
//   o_At_Target     applied speed equals the last accepted command
module motor_speed_ramp #(
  parameter int MULTIPLY_BY     = 33003,
  parameter int STEP_CYCLES     = 1000000,
  parameter int DEADTIME_CYCLES = 5000000
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_Cmd_Valid,
  input  logic [7:0]  i_Cmd_Speed,
  output logic        o_Cmd_Ready,
  output logic [23:0] o_Control_Range,
  output logic        o_Direction,
  output logic        o_At_Target
);

  localparam int PS_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int DT_W = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;
  localparam logic [PS_W-1:0] PS_TC   = PS_W'(STEP_CYCLES - 1);
  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME_CYCLES - 1);
  localparam logic [23:0]     SCALE   = 24'(MULTIPLY_BY);

  typedef enum logic [1:0] {IDLE, RAMP, DEADTIME} state_t;

  state_t          state, state_nxt;
  logic [6:0]      mag, mag_nxt;
  logic [6:0]      tgt_mag, tgt_mag_nxt;
  logic            dir, dir_nxt;
  logic            tgt_dir, tgt_dir_nxt;
  logic [PS_W-1:0] presc, presc_nxt;
  logic [DT_W-1:0] dt_cnt, dt_cnt_nxt;

  logic signed [7:0] cmd_s;
  logic [6:0]        cmd_mag;
  logic              cmd_dir;
  logic              cmd_same;

  // Clamp to +/-100 and split into magnitude and direction. A zero command
  // carries no direction of its own, so it keeps the applied one.
  always_comb begin
    cmd_s = signed'(i_Cmd_Speed);
    if (cmd_s > 8'sd100 || cmd_s < -8'sd100)
      cmd_mag = 7'd100;
    else if (cmd_s[7])
      cmd_mag = 7'(-cmd_s);
    else
      cmd_mag = cmd_s[6:0];
    cmd_dir  = (cmd_mag == 7'd0) ? dir : cmd_s[7];
    cmd_same = (cmd_mag == mag) && ((cmd_dir == dir) || (cmd_mag == 7'd0));
  end

  assign o_Cmd_Ready = (state == IDLE) && i_Rst_L;
  assign o_At_Target = (state == IDLE);
  assign o_Direction = dir;

  always_comb begin
    state_nxt   = state;
    mag_nxt     = mag;
    tgt_mag_nxt = tgt_mag;
    dir_nxt     = dir;
    tgt_dir_nxt = tgt_dir;
    presc_nxt   = presc;
    dt_cnt_nxt  = dt_cnt;
    case (state)
      IDLE: begin
        if (i_Cmd_Valid && o_Cmd_Ready && !cmd_same) begin
          tgt_mag_nxt = cmd_mag;
          tgt_dir_nxt = cmd_dir;
          presc_nxt   = '0;
          state_nxt   = RAMP;
          // Already stopped: a reversal needs no dead time.
          if (mag == 7'd0)
            dir_nxt = cmd_dir;
        end
      end
      RAMP: begin
        if (mag == 7'd0 && tgt_dir != dir) begin
          state_nxt  = DEADTIME;
          dt_cnt_nxt = DT_LOAD;
        end else if (mag == tgt_mag && tgt_dir == dir) begin
          state_nxt = IDLE;
        end else begin
          if (presc == PS_TC) begin
            presc_nxt = '0;
            // While reversing, always head toward zero first.
            if (tgt_dir != dir || mag > tgt_mag)
              mag_nxt = mag - 7'd1;
            else
              mag_nxt = mag + 7'd1;
          end else begin
            presc_nxt = presc + PS_W'(1);
          end
        end
      end
      DEADTIME: begin
        if (dt_cnt == '0) begin
          dir_nxt   = tgt_dir;
          presc_nxt = '0;
          state_nxt = (tgt_mag == 7'd0) ? IDLE : RAMP;
        end else begin
          dt_cnt_nxt = dt_cnt - DT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state           <= IDLE;
      mag             <= '0;
      tgt_mag         <= '0;
      dir             <= 1'b0;
      tgt_dir         <= 1'b0;
      presc           <= '0;
      dt_cnt          <= '0;
      o_Control_Range <= '0;
    end else begin
      state           <= state_nxt;
      mag             <= mag_nxt;
      tgt_mag         <= tgt_mag_nxt;
      dir             <= dir_nxt;
      tgt_dir         <= tgt_dir_nxt;
      presc           <= presc_nxt;
      dt_cnt          <= dt_cnt_nxt;
      o_Control_Range <= {17'd0, mag} * SCALE;
    end
  end

endmodule

// File: tb/tb_motor_speed_ramp.sv
// tb_motor_speed_ramp
// Directed bench for motor_speed_ramp with STEP_CYCLES=4, DEADTIME_CYCLES=8.
// Each accepted command pushes the expected output trajectory (cycle, range,
// direction, idle) derived from the ramp/dead-time timing rules; the queue is
// popped and compared as the matching cycles are reached.
module tb_motor_speed_ramp;

  localparam int MULT = 33003;
  localparam int STEP = 4;
  localparam int DT   = 8;
  localparam int MAXR = 100 * MULT;

  logic        i_Clk = 1'b0;
  logic        i_Rst_L;
  logic        i_Cmd_Valid;
  logic [7:0]  i_Cmd_Speed;
  logic        o_Cmd_Ready;
  logic [23:0] o_Control_Range;
  logic        o_Direction;
  logic        o_At_Target;

  motor_speed_ramp #(
    .MULTIPLY_BY(MULT),
    .STEP_CYCLES(STEP),
    .DEADTIME_CYCLES(DT)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst_L(i_Rst_L),
    .i_Cmd_Valid(i_Cmd_Valid),
    .i_Cmd_Speed(i_Cmd_Speed),
    .o_Cmd_Ready(o_Cmd_Ready),
    .o_Control_Range(o_Control_Range),
    .o_Direction(o_Direction),
    .o_At_Target(o_At_Target)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    int          cyc;
    logic [23:0] rng;
    logic        dir;
    logic        idle;
  } exp_t;

  exp_t q[$];
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;
  int   cur_mag = 0;
  bit   cur_dir = 1'b0;
  logic prev_dir = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic push(input int c, input int m, input bit d, input bit idle);
    exp_t e;
    e.cyc  = c;
    e.rng  = 24'(m * MULT);
    e.dir  = d;
    e.idle = idle;
    q.push_back(e);
  endtask

  // One clock; sample 1 time unit after the edge, then score anything due now.
  task automatic tick();
    exp_t e;
    @(posedge i_Clk);
    #1;
    cycle++;
    chk("range_limit", 32'(o_Control_Range <= 24'(MAXR)), 32'd1);
    if (o_Direction !== prev_dir)
      chk("dir_flip_at_zero", 32'(o_Control_Range), 32'd0);
    prev_dir = o_Direction;
    while (q.size() > 0 && q[0].cyc == cycle) begin
      e = q.pop_front();
      chk("range", 32'(o_Control_Range), 32'(e.rng));
      chk("direction", 32'(o_Direction), 32'(e.dir));
      chk("at_target", 32'(o_At_Target), 32'(e.idle));
      chk("ready", 32'(o_Cmd_Ready), 32'(e.idle));
    end
  endtask

  // Expected trajectory for a command accepted at edge t0.
  task automatic push_move(input int t0, input int m0, input bit d0, input int m1, input bit d1);
    int t;
    int n;
    int v;
    bit d;
    if (m0 > 0 && m1 > 0 && d1 != d0) begin
      for (int k = 1; k <= m0; k++)
        push(t0 + STEP * k + 1, m0 - k, d0, 1'b0);
      t = t0 + STEP * m0 + 1 + DT;
      push(t, 0, d1, 1'b0);
      for (int k = 1; k <= m1; k++)
        push(t + STEP * k + 1, k, d1, k == m1);
    end else begin
      d = (m1 == 0) ? d0 : d1;
      n = (m1 > m0) ? m1 - m0 : m0 - m1;
      for (int k = 1; k <= n; k++) begin
        v = (m1 > m0) ? m0 + k : m0 - k;
        push(t0 + STEP * k + 1, v, d, k == n);
      end
    end
  endtask

  task automatic send(input int cmd, input int m1, input bit d1);
    int t0;
    i_Cmd_Valid = 1'b1;
    i_Cmd_Speed = 8'(cmd);
    chk("ready_at_accept", 32'(o_Cmd_Ready), 32'd1);
    tick();
    i_Cmd_Valid = 1'b0;
    t0 = cycle;
    push_move(t0, cur_mag, cur_dir, m1, d1);
    cur_mag = m1;
    if (m1 != 0) cur_dir = d1;
  endtask

  task automatic drain();
    int lim;
    lim = cycle + 2000;
    while (q.size() > 0 && cycle < lim) tick();
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic apply_reset();
    i_Rst_L = 1'b0;
    q.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_range", 32'(o_Control_Range), 32'd0);
      chk("rst_dir", 32'(o_Direction), 32'd0);
      chk("rst_at_target", 32'(o_At_Target), 32'd1);
      chk("rst_ready", 32'(o_Cmd_Ready), 32'd0);
    end
    i_Rst_L = 1'b1;
    #1;
    chk("post_rst_ready", 32'(o_Cmd_Ready), 32'd1);
    chk("post_rst_at_target", 32'(o_At_Target), 32'd1);
    cur_mag = 0;
    cur_dir = 1'b0;
  endtask

  initial begin
    int t0;
    i_Rst_L     = 1'b0;
    i_Cmd_Valid = 1'b0;
    i_Cmd_Speed = 8'd0;

    // Reset
    apply_reset();

    // Ramp up to +3 with a busy command in the middle that must be ignored
    send(3, 3, 1'b0);
    tick();
    tick();
    i_Cmd_Valid = 1'b1;
    i_Cmd_Speed = 8'd50;
    chk("busy_ready", 32'(o_Cmd_Ready), 32'd0);
    tick();
    i_Cmd_Valid = 1'b0;
    drain();
    chk("ramp_final", 32'(o_Control_Range), 32'd99009);

    // Reversal to -2 with dead time
    send(-2, 2, 1'b1);
    drain();
    chk("rev_final", 32'(o_Control_Range), 32'd66006);
    chk("rev_dir", 32'(o_Direction), 32'd1);

    // Clamp: +120 acts as +100, -128 acts as -100
    send(120, 100, 1'b0);
    drain();
    chk("clamp_pos", 32'(o_Control_Range), 32'd3300300);
    chk("clamp_pos_dir", 32'(o_Direction), 32'd0);
    send(-128, 100, 1'b1);
    drain();
    chk("clamp_neg", 32'(o_Control_Range), 32'd3300300);
    chk("clamp_neg_dir", 32'(o_Direction), 32'd1);

    // Reset in the middle of a dead time
    apply_reset();
    send(3, 3, 1'b0);
    drain();
    send(-2, 2, 1'b1);
    t0 = cycle;
    while (cycle < t0 + 16) tick();
    i_Rst_L = 1'b0;
    q.delete();
    tick();
    chk("midrst_range", 32'(o_Control_Range), 32'd0);
    chk("midrst_dir", 32'(o_Direction), 32'd0);
    chk("midrst_at_target", 32'(o_At_Target), 32'd1);
    i_Rst_L = 1'b1;
    cur_mag = 0;
    cur_dir = 1'b0;
    #1;
    send(1, 1, 1'b0);
    drain();
    chk("fresh_cmd", 32'(o_Control_Range), 32'd33003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_speed_ramp.md
# motor_speed_ramp

Setpoint stage directly upstream of the DC motor PWM controller. It accepts a signed percent-speed command over a valid/ready handshake. It slews the applied speed toward that command one percent per step interval and forces a zero-speed dead time before any reversal. Its output is the 24-bit control range (percent × scale) that drives the PWM controller's `i_Control_Range`, plus a registered direction bit.

## Interface
- `MULTIPLY_BY`, default 33003: control-range counts per 1 % duty. Constraint: `MULTIPLY_BY*100 < 2^24`.
- `STEP_CYCLES`, default 1000000: clocks per 1 % ramp step (10 ms at 100 MHz). Must be ≥ 2.
- `DEADTIME_CYCLES`, default 5000000: clocks held at zero before a direction flip. Must be ≥ 1.
- `i_Clk`, in, 1: system clock, 100 MHz.
- `i_Rst_L`, in, 1: reset. Synchronous, active-low.
- `i_Cmd_Valid`, in, 1: command strobe.
- `i_Cmd_Speed`, in, 8: signed two's-complement percent (−100..+100). Positive = clockwise.
- `o_Cmd_Ready`, out, 1: block accepts a command this cycle.
- `o_Control_Range`, out, 24: applied magnitude × `MULTIPLY_BY`, registered.
- `o_Direction`, out, 1: 0 = clockwise, 1 = counterclockwise.
- `o_At_Target`, out, 1: applied speed equals the last accepted command.

## Operation
**States:**
- IDLE
- RAMP
- DEADTIME

**Internal registers:**
- `mag[6:0]`: applied magnitude.
- `dir`: applied direction.
- `tgt_mag[6:0]`, `tgt_dir`: target.
- Prescaler.
- Dead-time counter.

**Command clamp:**
- Values above +100 become +100. Values below −100 (including −128) become −100.
- `tgt_mag` = |clamped value|.
- `tgt_dir` = sign bit of the clamped value.
- For a command of 0, `tgt_dir` keeps the current `dir`.

**Accept:** a command is accepted on `i_Cmd_Valid && o_Cmd_Ready`. `o_Cmd_Ready` = (state == IDLE) and reset is deasserted.

**IDLE:**
- If the accepted command equals the applied speed (same magnitude, and same direction or both zero), stay in IDLE.
- Otherwise latch the target, clear the prescaler and go to RAMP.

**RAMP:**
- The prescaler counts 0..`STEP_CYCLES`−1. At terminal count it wraps to 0 and `mag` moves by 1.
- Reversal pending (`tgt_dir != dir` and `mag > 0`): `mag` decrements toward 0.
- Otherwise `mag` moves ±1 toward `tgt_mag`.
- If the step sets `mag` to 0 with a reversal pending, go to DEADTIME on the next edge.
- If the step sets `mag` equal to `tgt_mag` with no reversal pending, go to IDLE on the next edge.
- Special case: a reversal command while `mag == 0` flips `dir` on the accept edge with no dead time. The motor is already stopped.

**DEADTIME:**
- Counts `DEADTIME_CYCLES`.
- At expiry: `dir <= tgt_dir`, prescaler cleared, go to RAMP. If `tgt_mag == 0`, go to IDLE instead.

**Outputs:**
- `o_Control_Range <= mag * MULTIPLY_BY` every clock; one cycle behind `mag`.
- `o_Direction` is the registered `dir`.
- `o_At_Target` = (state == IDLE).

**Busy commands:** `i_Cmd_Valid` while not in IDLE is ignored. There is no queueing and the target is unchanged.

## Timing
**Reset** (`i_Rst_L` low at a rising edge) forces, on that edge:
- State = IDLE.
- `mag`, `tgt_mag`, prescaler and dead-time counter = 0.
- `dir`, `tgt_dir` = 0.
- `o_Control_Range` = 0, `o_Direction` = 0.
- `o_Cmd_Ready` is 0 while reset is held. `o_At_Target` = 1.

Reset mid-ramp or mid-dead-time is abandoned immediately; the same values apply.

**Ramp timing**, with the command accepted at edge 0:
- Steps occur at edges `STEP_CYCLES`, 2×`STEP_CYCLES`, and so on.
- `o_Control_Range` reflects each step one edge later.
- For the final step at edge m: `o_Control_Range` takes its final value at m+1, and IDLE/ready/at-target assert at m+1.

**Reversal timing:**
- `mag` reaches 0 at edge m.
- `o_Control_Range` = 0 and DEADTIME is entered at m+1.
- `o_Direction` flips at m+1+`DEADTIME_CYCLES`.
- The first up-step follows `STEP_CYCLES` later.
- `o_Direction` never changes while `o_Control_Range` ≠ 0.

**Arithmetic:** `mag` never exceeds 100, so `o_Control_Range` ≤ 3,300,300 at the default scale. The multiply is unsigned 7 × 24-bit, truncated to 24 bits; the parameter constraint guarantees no overflow.

## Test plan
All scenarios use `STEP_CYCLES`=4, `DEADTIME_CYCLES`=8, `MULTIPLY_BY`=33003.
1. **Reset.** Hold `i_Rst_L` low for 3 cycles, then release. Required: `o_Control_Range`=0, `o_Direction`=0, `o_At_Target`=1; `o_Cmd_Ready`=0 during reset and 1 after release.
2. **Ramp up.** Accept +3 at edge 0. Required: `o_Control_Range` = 33003 @5, 66006 @9, 99009 @13; `o_Cmd_Ready` and `o_At_Target` return to 1 @13; `o_Direction`=0 throughout.
3. **Reversal.** From +3 settled, accept −2 at edge 0. Required: range 66006 @5, 33003 @9, 0 @13; `o_Direction` flips to 1 @21 while range = 0; range 33003 @26, 66006 @30; IDLE @30.
4. **Clamp.** Accept +120, then separately −128. Required: final range 3,300,300 with `o_Direction`=0, then 3,300,300 with `o_Direction`=1. No value ever exceeds 3,300,300.
5. **Busy command ignored.** Pulse `i_Cmd_Valid` with +50 during the ramp of scenario 2. Required: `o_Cmd_Ready`=0 at that cycle; the ramp still settles at 99009.
6. **Reset mid-operation.** Assert reset during DEADTIME of scenario 3. Required: the next edge gives range 0, `o_Direction`=0, IDLE. A fresh command of +1 then yields 33003 five edges after accept.
